// File: rtl/upower_pkg.sv
// Shared types and constants for the uPOWER fetch stage.
// Holds the default PC width, the instruction width, the NOP encoding and the fetch FSM states.
package upower_pkg;

    localparam int DEFAULT_PC_W = 32;
    localparam int INSTR_W      = 32;

    // ori 0,0,0 - placed in IF/ID whenever no real instruction is present
    localparam logic [INSTR_W-1:0] UPOWER_NOP = 32'h6000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/upower_fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count.
// Used both as the prefetch buffer and as the in-order request-PC tag queue.
module upower_fetch_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign head    = mem[rd_ptr];
    // a push into a full FIFO is legal only when the head leaves in the same cycle
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/upower_fetch_stage.sv
// uPOWER instruction-fetch stage: PC, imem request/response, prefetch buffer and IF/ID register.
// State table:
//   state    | meaning
//   ST_BOOT  | first cycle out of reset, no requests issued
//   ST_RUN   | normal fetching, responses delivered to IF/ID
//   ST_FLUSH | wrong-path responses still in flight, dropped as they return
module upower_fetch_stage
    import upower_pkg::*;
#(
    parameter int              PC_W       = DEFAULT_PC_W,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               stall_id,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               ifid_valid,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [INSTR_W-1:0] ifid_instr
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = PC_W + INSTR_W;

    fetch_state_e     state;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] discard_nxt;
    logic [CNT_W:0]   credit_used;

    logic             req_fire;
    logic             rsp_keep;
    logic             ifid_free;

    logic             pf_push;
    logic             pf_pop;
    logic [ENT_W-1:0] pf_head;
    logic [CNT_W-1:0] pf_count;
    logic             pf_empty;
    logic             pf_full;

    logic [PC_W-1:0]  tag_head;
    logic [CNT_W-1:0] tag_count;
    logic             tag_empty;
    logic             tag_full;

    // buffered entries count against the credit so the prefetch FIFO can never overflow
    assign credit_used    = {1'b0, outstanding} + {1'b0, pf_count};
    assign imem_req_valid = (state != ST_BOOT) && !redirect_valid &&
                            (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_keep  = imem_rsp_valid && !redirect_valid && (discard == '0);
    assign ifid_free = !ifid_valid || !stall_id;
    assign pf_pop    = ifid_free && !pf_empty && !redirect_valid;
    assign pf_push   = rsp_keep && !(pf_empty && ifid_free);

    assign outstanding_nxt = outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

    always_comb begin
        discard_nxt = discard;
        if (redirect_valid)
            discard_nxt = outstanding_nxt;
        else if (imem_rsp_valid && (discard != '0))
            discard_nxt = discard - 1'b1;
    end

    upower_fetch_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_prefetch (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (pf_push),
        .push_data ({tag_head, imem_rsp_data}),
        .pop       (pf_pop),
        .head      (pf_head),
        .count     (pf_count),
        .empty     (pf_empty),
        .full      (pf_full)
    );

    // tags follow every response, dropped or not, so they are never flushed
    upower_fetch_fifo #(.W(PC_W), .DEPTH(FIFO_DEPTH)) u_tag_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (pc),
        .pop       (imem_rsp_valid),
        .head      (tag_head),
        .count     (tag_count),
        .empty     (tag_empty),
        .full      (tag_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            ifid_valid  <= 1'b0;
            ifid_pc     <= '0;
            ifid_instr  <= UPOWER_NOP;
        end else begin
            outstanding <= outstanding_nxt;
            discard     <= discard_nxt;
            state       <= (state == ST_BOOT || discard_nxt == '0) ? ST_RUN : ST_FLUSH;

            if (redirect_valid)
                pc <= redirect_pc & ~PC_W'(3);
            else if (req_fire)
                pc <= pc + PC_W'(4);

            if (redirect_valid) begin
                ifid_valid <= 1'b0;
                ifid_instr <= UPOWER_NOP;
            end else if (ifid_free) begin
                if (!pf_empty) begin
                    ifid_valid <= 1'b1;
                    ifid_pc    <= pf_head[ENT_W-1:INSTR_W];
                    ifid_instr <= pf_head[INSTR_W-1:0];
                end else if (rsp_keep) begin
                    ifid_valid <= 1'b1;
                    ifid_pc    <= tag_head;
                    ifid_instr <= imem_rsp_data;
                end else begin
                    ifid_valid <= 1'b0;
                    ifid_instr <= UPOWER_NOP;
                end
            end
        end
    end

    a_no_pf_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(pf_push && pf_full && !pf_pop));
    a_tag_tracks_outstanding: assert property (@(posedge clk) disable iff (!reset)
        (tag_count == outstanding) && !(req_fire && tag_full) && !(imem_rsp_valid && tag_empty));

endmodule

// File: tb/tb_upower_fetch_stage.sv
// Directed bench for upower_fetch_stage with a behavioural imem of selectable latency.
// Instruction words returned by imem are 32'hC000_0000 | address.
module tb_upower_fetch_stage;
    import upower_pkg::*;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall_id;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;

    int total = 0;
    int bad   = 0;

    int          lat = 1;
    logic        pv [1:3];
    logic [31:0] pa [1:3];
    logic        hs;
    logic [31:0] hs_addr;

    upower_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall_id       (stall_id),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_valid     (ifid_valid),
        .ifid_pc        (ifid_pc),
        .ifid_instr     (ifid_instr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // imem: handshake seen at the negedge, response presented lat cycles after the accepting edge
    initial begin
        for (int i = 1; i <= 3; i++) begin
            pv[i] = 1'b0;
            pa[i] = '0;
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            hs      = imem_req_valid && imem_req_ready;
            hs_addr = imem_req_addr;
            @(posedge clk);
            #1;
            if (!reset) begin
                for (int i = 1; i <= 3; i++) begin
                    pv[i] = 1'b0;
                    pa[i] = '0;
                end
            end else begin
                pv[3] = pv[2]; pa[3] = pa[2];
                pv[2] = pv[1]; pa[2] = pa[1];
                pv[1] = hs;    pa[1] = hs_addr;
            end
            imem_rsp_valid = pv[lat];
            imem_rsp_data  = 32'hC000_0000 | pa[lat];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ifid_valid"}, {31'b0, ifid_valid}, 32'd0);
        chk({tag, "_ifid_pc"}, ifid_pc, 32'h0);
        chk({tag, "_ifid_instr"}, ifid_instr, 32'h6000_0000);
        chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        chk({tag, "_req_addr"}, imem_req_addr, 32'h0);
    endtask

    initial begin
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        stall_id       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        #12;
        chk_reset_values("por");
        reset = 1'b1;

        // zero-wait streaming
        step(1);
        chk("boot_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("boot_req_addr", imem_req_addr, 32'h0);
        step(1);
        chk("first_latency_valid", {31'b0, ifid_valid}, 32'd0);
        chk("second_req_addr", imem_req_addr, 32'h4);
        step(1);
        chk("stream0_valid", {31'b0, ifid_valid}, 32'd1);
        chk("stream0_pc", ifid_pc, 32'h0);
        chk("stream0_instr", ifid_instr, 32'hC000_0000);
        step(1);
        chk("stream1_pc", ifid_pc, 32'h4);

        // ID stall for three cycles
        stall_id = 1'b1;
        step(1);
        chk("stall_hold_a", ifid_pc, 32'h4);
        step(1);
        chk("stall_hold_b", ifid_pc, 32'h4);
        chk("stall_credit_b", {31'b0, imem_req_valid}, 32'd0);
        step(1);
        chk("stall_hold_c", ifid_pc, 32'h4);
        chk("stall_valid_c", {31'b0, ifid_valid}, 32'd1);
        chk("stall_credit_c", {31'b0, imem_req_valid}, 32'd0);
        stall_id = 1'b0;
        step(1);
        chk("resume_pc8", ifid_pc, 32'h8);
        chk("resume_instr8", ifid_instr, 32'hC000_0008);
        step(1);
        chk("resume_pcC", ifid_pc, 32'hC);
        step(1);
        chk("resume_pc10", ifid_pc, 32'h10);
        step(1);
        chk("resume_pc14", ifid_pc, 32'h14);

        // imem not ready for five cycles
        imem_req_ready = 1'b0;
        step(1);
        chk("notready_last_pc", ifid_pc, 32'h18);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("notready_addr", imem_req_addr, 32'h1C);
            chk("notready_req_valid", {31'b0, imem_req_valid}, 32'd1);
            chk("notready_ifid_valid", {31'b0, ifid_valid}, 32'd0);
            chk("notready_ifid_instr", ifid_instr, 32'h6000_0000);
        end

        // three-cycle imem: two requests in flight, then redirect to an unaligned target
        lat = 3;
        imem_req_ready = 1'b1;
        step(1);
        chk("lat3_req_addr", imem_req_addr, 32'h20);
        step(1);
        chk("lat3_credit_full", {31'b0, imem_req_valid}, 32'd0);
        chk("lat3_pc", imem_req_addr, 32'h24);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        step(1);
        redirect_valid = 1'b0;
        chk("redir_ifid_valid", {31'b0, ifid_valid}, 32'd0);
        chk("redir_addr_masked", imem_req_addr, 32'h40);
        chk("redir_req_blocked", {31'b0, imem_req_valid}, 32'd0);
        step(1);
        chk("flush_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("flush_req_addr", imem_req_addr, 32'h40);
        chk("flush_drop_a", {31'b0, ifid_valid}, 32'd0);
        step(1);
        chk("flush_next_addr", imem_req_addr, 32'h44);
        chk("flush_drop_b", {31'b0, ifid_valid}, 32'd0);
        step(1);
        chk("flush_drop_c", {31'b0, ifid_valid}, 32'd0);
        step(1);
        chk("flush_drop_d", {31'b0, ifid_valid}, 32'd0);
        step(1);
        chk("target_valid", {31'b0, ifid_valid}, 32'd1);
        chk("target_pc", ifid_pc, 32'h40);
        chk("target_instr", ifid_instr, 32'hC000_0040);
        step(1);
        chk("target_next_pc", ifid_pc, 32'h44);

        // asynchronous reset between edges
        #2;
        reset = 1'b0;
        #1;
        chk_reset_values("async");
        step(1);
        lat = 1;
        #2;
        reset = 1'b1;
        step(1);
        chk("rerun_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("rerun_req_addr", imem_req_addr, 32'h0);
        step(2);
        chk("rerun_ifid_pc", ifid_pc, 32'h0);
        chk("rerun_ifid_valid", {31'b0, ifid_valid}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
